mem_access_unit: RTL

Memory-stage access unit placed directly downstream of the execute-stage ALU block. It takes the ALU result as the effective address and the second register operand as store data, and runs a single load or store over a req/ack data bus. Loads are byte/half/word aligned and sign- or zero-extended. While an access is in flight it holds the pipeline with `busy`.

---
 rtl/mem_pkg.sv | 58 +++++
 rtl/load_align.sv | 32 +++
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and helpers for the memory access unit
//
// Contents: mem_op encodings, FSM state enum, byte-enable constants,
// alignment / lane / store classification helpers.
package mem_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    function automatic logic is_store(input mem_op_e op);
        logic r;
        r = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
        return r;
    endfunction

    // Only LW checks both offset bits; SW shares the halfword rule.
    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] off);
        logic r;
        case (op)
            OP_LW:                     r = (off != 2'b00);
            OP_LH, OP_LHU, OP_SH, OP_SW: r = off[0];
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_be(input mem_op_e op, input logic [1:0] off);
        logic [3:0] r;
        case (op)
            OP_LW, OP_SW:         r = BE_WORD;
            OP_LH, OP_LHU, OP_SH: r = off[1] ? BE_HALF_HI : BE_HALF_LO;
            default:              r = BE_BYTE0 << off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends the addressed lane of a read word
//
// Ports:
//   op_i   : access type (load variants are meaningful)
//   off_i  : addr[1:0] of the access
//   word_i : raw 32-bit bus read word
//   data_o : aligned, sign/zero-extended load result
module load_align
    import mem_pkg::*;
(
    input  mem_op_e     op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{off_i, 3'b000} +: 8];
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (op_i)
            OP_LH:   data_o = {{16{half_v[15]}}, half_v};
            OP_LHU:  data_o = {16'h0000, half_v};
            OP_LB:   data_o = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  data_o = {24'h000000, byte_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage single load/store over a req/ack bus
//
// Optional feature macro: MEM_TIMEOUT_EN (bus watchdog of TIMEOUT_CYCLES).
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   req_valid, mem_op, addr, wdata : access request from execute stage
//   busy                         : pipeline stall (combinational)
//   done, rdata, misaligned, bus_err : completion pulse and status
//   bus_req, bus_we, bus_addr, bus_be, bus_wdata : bus request side
//   bus_ack, bus_rdata           : bus response side
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_e      state_q, state_d;
    mem_op_e     op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] load_data;
    logic        accept;
    logic        in_req;
    logic [31:0] placed_wdata;

    assign accept = (state_q == ST_IDLE) && req_valid;
    assign in_req = (state_q == ST_REQ);

    load_align u_load_align (
        .op_i   (op_q),
        .off_i  (addr_q[1:0]),
        .word_i (bus_rdata),
        .data_o (load_data)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             expired;

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rdata_d = '0;
                    state_d = is_misaligned(mem_op_e'(mem_op), addr[1:0]) ? ST_ERR : ST_REQ;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ST_REQ: begin
                // Ack beats a same-cycle watchdog expiry.
                if (bus_ack) begin
                    rdata_d = is_store(op_q) ? 32'h0 : load_data;
                    state_d = ST_RESP;
`ifdef MEM_TIMEOUT_EN
                end else if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
            if (accept) begin
                op_q    <= mem_op_e'(mem_op);
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        case (op_q)
            OP_SH:   placed_wdata = {2{wdata_q[15:0]}};
            OP_SB:   placed_wdata = {4{wdata_q[7:0]}};
            default: placed_wdata = wdata_q;
        endcase
    end

    // Bus outputs are forced to zero outside REQ so idle/reset values are clean.
    assign bus_req    = in_req;
    assign bus_we     = in_req && is_store(op_q);
    assign bus_addr   = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_be     = in_req ? lane_be(op_q, addr_q[1:0]) : BE_NONE;
    assign bus_wdata  = (in_req && is_store(op_q)) ? placed_wdata : 32'h0;

    assign busy       = (state_q != ST_IDLE) || req_valid;
    assign done       = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign misaligned = (state_q == ST_ERR);
    assign rdata      = (state_q == ST_RESP) ? rdata_q : 32'h0;

`ifdef MEM_TIMEOUT_EN
    assign bus_err    = (state_q == ST_RESP) && err_q;
`else
    assign bus_err    = 1'b0;
`endif

endmodule
